// File: rtl/usb_ep_scheduler_pkg.sv
// Shared handshake codes, scheduler FSM states and packet-size default for the
// USB endpoint scheduler.
package usb_ep_scheduler_pkg;

  localparam int MAX_PKT_DEFAULT = 64;

  typedef enum logic [1:0] {
    hs_ack   = 2'b00,
    hs_none  = 2'b01,
    hs_nak   = 2'b10,
    hs_stall = 2'b11
  } hs_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECIDE   = 3'd1,
    ST_IN_XFER  = 3'd2,
    ST_OUT_XFER = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

endpackage

// File: rtl/usb_ep_scheduler_if.sv
// Transaction port between the usbcorev core (master) and the endpoint
// scheduler (slave).
interface usb_ep_scheduler_if;
  logic [3:0] endpoint;
  logic       transaction_active;
  logic       direction_in;
  logic       setup;
  logic       data_strobe;
  logic       success;
  logic [7:0] data_out;
  logic [1:0] handshake;
  logic       data_toggle;
  logic [7:0] data_in;
  logic       data_in_valid;

  modport master (
    output endpoint, transaction_active, direction_in, setup, data_strobe,
           success, data_out,
    input  handshake, data_toggle, data_in, data_in_valid
  );

  modport slave (
    input  endpoint, transaction_active, direction_in, setup, data_strobe,
           success, data_out,
    output handshake, data_toggle, data_in, data_in_valid
  );
endinterface

// File: rtl/usb_ep_scheduler_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle registers for the IN and OUT directions.
// A committed SETUP forces both EP0 toggles to DATA1.
module usb_ep_scheduler_toggle_bank #(
  parameter int NUM_EP = 4
) (
  input  logic              clk48mhz,
  input  logic              rst,
  input  logic [NUM_EP-1:0] in_flip,
  input  logic [NUM_EP-1:0] out_flip,
  input  logic              ep0_set,
  output logic [NUM_EP-1:0] in_tog,
  output logic [NUM_EP-1:0] out_tog
);

  always_ff @(posedge clk48mhz) begin
    if (rst) begin
      in_tog  <= '0;
      out_tog <= '0;
    end else begin
      in_tog  <= in_tog ^ in_flip;
      out_tog <= out_tog ^ out_flip;
      if (ep0_set) begin
        in_tog[0]  <= 1'b1;
        out_tog[0] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_ep_scheduler.sv
// Endpoint scheduler: decides the handshake per token, muxes IN bytes from the
// selected endpoint, fans OUT/SETUP bytes out and reports commit/abort/done.
module usb_ep_scheduler
  import usb_ep_scheduler_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = MAX_PKT_DEFAULT
) (
  input  logic                clk48mhz,
  input  logic                rst,
  input  logic                usb_rst,
  usb_ep_scheduler_if.slave   usb,
  input  logic [NUM_EP-1:0]   ep_stall,
  input  logic [NUM_EP-1:0]   ep_in_ready,
  input  logic [NUM_EP*7-1:0] ep_in_len,
  input  logic [NUM_EP*8-1:0] ep_in_data,
  output logic [6:0]          in_addr,
  output logic [NUM_EP-1:0]   ep_in_done,
  output logic [7:0]          out_byte,
  output logic                out_is_setup,
  input  logic [NUM_EP-1:0]   ep_out_ready,
  output logic [NUM_EP-1:0]   ep_out_wr,
  output logic [NUM_EP-1:0]   ep_out_commit,
  output logic [NUM_EP-1:0]   ep_out_abort
);

  logic srst;
  state_e state;
  logic ta_p1, ds_p1;
  logic ta_rise, ta_fall, ds_rise;
  logic [3:0] ep_q;
  logic [6:0] len_q, cnt_q;
  logic ovf_q;
  logic [NUM_EP-1:0] in_tog, out_tog, in_flip, out_flip, ep_oh;
  logic ep0_set;
  logic tok_valid, tok_stall, tok_in_rdy, tok_out_rdy, tok_in_tog, tok_out_tog;
  logic [6:0] tok_len;
  logic [7:0] cur_data;
  logic in_vld, wr_now, end_in_ok, end_out, end_out_ok;
  hs_e hs_next;

  function automatic hs_e decide_hs(input logic is_setup, input logic ep_is0,
                                    input logic valid, input logic stall,
                                    input logic dir_in, input logic in_rdy,
                                    input logic out_rdy);
    if (is_setup) return ep_is0 ? hs_ack : hs_stall;
    if (!valid || stall) return hs_stall;
    if (dir_in ? !in_rdy : !out_rdy) return hs_nak;
    return hs_ack;
  endfunction

  assign srst    = rst | usb_rst;
  assign ta_rise = usb.transaction_active && !ta_p1;
  assign ta_fall = !usb.transaction_active && ta_p1;
  assign ds_rise = usb.data_strobe && !ds_p1;

  // Token-side lookups use the live endpoint; data-side lookups use the latched one.
  always_comb begin
    tok_valid   = 1'b0;
    tok_stall   = 1'b0;
    tok_in_rdy  = 1'b0;
    tok_out_rdy = 1'b0;
    tok_in_tog  = 1'b0;
    tok_out_tog = 1'b0;
    tok_len     = '0;
    cur_data    = '0;
    ep_oh       = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (usb.endpoint == 4'(i)) begin
        tok_valid   = 1'b1;
        tok_stall   = ep_stall[i];
        tok_in_rdy  = ep_in_ready[i];
        tok_out_rdy = ep_out_ready[i];
        tok_in_tog  = in_tog[i];
        tok_out_tog = out_tog[i];
        tok_len     = ep_in_len[i*7 +: 7];
      end
      if (ep_q == 4'(i)) begin
        cur_data = ep_in_data[i*8 +: 8];
        ep_oh[i] = 1'b1;
      end
    end
  end

  assign hs_next = decide_hs(usb.setup, usb.endpoint == 4'd0, tok_valid, tok_stall,
                             usb.direction_in, tok_in_rdy, tok_out_rdy);

  assign in_vld            = (state == ST_IN_XFER) && (in_addr < len_q);
  assign usb.data_in_valid = in_vld;
  assign usb.data_in       = in_vld ? cur_data : 8'h00;

  assign wr_now     = (state == ST_OUT_XFER) && !ta_fall && ds_rise && (cnt_q != 7'(MAX_PKT));
  assign end_in_ok  = (state == ST_IN_XFER) && ta_fall && usb.success;
  assign end_out    = (state == ST_OUT_XFER) && ta_fall;
  assign end_out_ok = end_out && usb.success && !ovf_q;
  assign in_flip    = end_in_ok ? ep_oh : '0;
  assign out_flip   = (end_out_ok && !out_is_setup) ? ep_oh : '0;
  assign ep0_set    = end_out_ok && out_is_setup;

  usb_ep_scheduler_toggle_bank #(.NUM_EP(NUM_EP)) u_toggle_bank (
    .clk48mhz (clk48mhz),
    .rst      (srst),
    .in_flip  (in_flip),
    .out_flip (out_flip),
    .ep0_set  (ep0_set),
    .in_tog   (in_tog),
    .out_tog  (out_tog)
  );

  always_ff @(posedge clk48mhz) begin
    ta_p1 <= usb.transaction_active;
    ds_p1 <= usb.data_strobe;
    if (srst) begin
      state           <= ST_IDLE;
      usb.handshake   <= hs_ack;
      usb.data_toggle <= 1'b0;
      in_addr         <= '0;
      out_is_setup    <= 1'b0;
      ep_in_done      <= '0;
      ep_out_wr       <= '0;
      ep_out_commit   <= '0;
      ep_out_abort    <= '0;
    end else begin
      ep_in_done    <= end_in_ok ? ep_oh : '0;
      ep_out_wr     <= wr_now ? ep_oh : '0;
      ep_out_commit <= end_out_ok ? ep_oh : '0;
      ep_out_abort  <= (end_out && !end_out_ok) ? ep_oh : '0;
      case (state)
        ST_IDLE: if (ta_rise) state <= ST_DECIDE;
        ST_DECIDE: begin
          if (ta_fall) begin
            state <= ST_IDLE;
          end else begin
            ep_q            <= usb.endpoint;
            len_q           <= tok_len;
            cnt_q           <= '0;
            ovf_q           <= 1'b0;
            in_addr         <= '0;
            out_is_setup    <= usb.setup;
            usb.handshake   <= hs_next;
            usb.data_toggle <= !usb.setup && (usb.direction_in ? tok_in_tog : tok_out_tog);
            if (hs_next != hs_ack)                   state <= ST_DRAIN;
            else if (usb.direction_in && !usb.setup) state <= ST_IN_XFER;
            else                                     state <= ST_OUT_XFER;
          end
        end
        ST_IN_XFER: begin
          if (ta_fall)                            state <= ST_IDLE;
          else if (ds_rise && (in_addr < len_q))  in_addr <= in_addr + 7'd1;
        end
        ST_OUT_XFER: begin
          if (ta_fall) begin
            state <= ST_IDLE;
          end else if (ds_rise) begin
            if (cnt_q == 7'(MAX_PKT)) ovf_q <= 1'b1;
            else                      cnt_q <= cnt_q + 7'd1;
          end
        end
        ST_DRAIN: if (ta_fall) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48mhz) begin
    if (wr_now) out_byte <= usb.data_out;
  end

endmodule

// File: tb/tb_usb_ep_scheduler.sv
// Scoreboard bench for usb_ep_scheduler: stimulus queues expected events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_usb_ep_scheduler;
  import usb_ep_scheduler_pkg::*;

  localparam int NUM_EP  = 4;
  localparam int MAX_PKT = 64;

  localparam logic [2:0] EV_HS = 3'd0, EV_VLD = 3'd1, EV_INB = 3'd2, EV_WR = 3'd3,
                         EV_COMMIT = 3'd4, EV_ABORT = 3'd5, EV_DONE = 3'd6;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] ep;
    logic       flag;
    logic [7:0] data;
  } ev_t;

  logic clk48mhz = 1'b0;
  logic rst, usb_rst;
  logic [NUM_EP-1:0] ep_stall, ep_in_ready, ep_out_ready;
  logic [NUM_EP-1:0] ep_in_done, ep_out_wr, ep_out_commit, ep_out_abort;
  logic [NUM_EP*7-1:0] ep_in_len;
  logic [NUM_EP*8-1:0] ep_in_data;
  logic [6:0] in_addr;
  logic [7:0] out_byte;
  logic out_is_setup;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  bit mon_en = 1'b0;

  always #10 clk48mhz = ~clk48mhz;

  usb_ep_scheduler_if usb();

  usb_ep_scheduler #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT)) dut (
    .clk48mhz      (clk48mhz),
    .rst           (rst),
    .usb_rst       (usb_rst),
    .usb           (usb),
    .ep_stall      (ep_stall),
    .ep_in_ready   (ep_in_ready),
    .ep_in_len     (ep_in_len),
    .ep_in_data    (ep_in_data),
    .in_addr       (in_addr),
    .ep_in_done    (ep_in_done),
    .out_byte      (out_byte),
    .out_is_setup  (out_is_setup),
    .ep_out_ready  (ep_out_ready),
    .ep_out_wr     (ep_out_wr),
    .ep_out_commit (ep_out_commit),
    .ep_out_abort  (ep_out_abort)
  );

  // Endpoint model: EP1 has a 3-byte packet; byte = {ep, addr} ^ 0x5A.
  assign ep_in_len = {7'd0, 7'd0, 7'd3, 7'd0};
  for (genvar e = 0; e < NUM_EP; e++) begin : g_epdata
    assign ep_in_data[e*8 +: 8] = {4'(e), in_addr[3:0]} ^ 8'h5A;
  end

  function automatic string kname(input logic [2:0] k);
    case (k)
      EV_HS:     return "handshake";
      EV_VLD:    return "in_valid_rise";
      EV_INB:    return "in_byte";
      EV_WR:     return "out_wr";
      EV_COMMIT: return "commit";
      EV_ABORT:  return "abort";
      EV_DONE:   return "in_done";
      default:   return "unknown";
    endcase
  endfunction

  function automatic ev_t mk(input logic [2:0] k, input logic [3:0] ep,
                             input logic f, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.ep = ep; e.flag = f; e.data = d;
    return e;
  endfunction

  task automatic push(input logic [2:0] k, input logic [3:0] ep,
                      input logic f, input logic [7:0] d);
    exp_q.push_back(mk(k, ep, f, d));
  endtask

  task automatic push_hs(input hs_e h, input logic tog);
    push(EV_HS, 4'd0, tog, {6'b0, h});
  endtask

  task automatic score(input ev_t got);
    ev_t req;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got ep=%0d flag=%0b data=%02h, required no event",
               kname(got.kind), got.ep, got.flag, got.data);
    end else begin
      req = exp_q.pop_front();
      if (got !== req) begin
        errors++;
        $display("FAIL %s: got %s ep=%0d flag=%0b data=%02h, required %s ep=%0d flag=%0b data=%02h",
                 kname(req.kind), kname(got.kind), got.ep, got.flag, got.data,
                 kname(req.kind), req.ep, req.flag, req.data);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: handshake/toggle two cycles after the token rise, plus all pulses.
  initial begin
    logic ta_prev = 1'b0, ds_prev = 1'b0, vld_prev = 1'b0;
    int hs_cnt = 0;
    forever begin
      @(negedge clk48mhz);
      if (mon_en) begin
        if (hs_cnt > 0) begin
          hs_cnt--;
          if (hs_cnt == 0) score(mk(EV_HS, 4'd0, usb.data_toggle, {6'b0, usb.handshake}));
        end
        if (usb.transaction_active && !ta_prev) hs_cnt = 2;
        if (usb.data_in_valid && !vld_prev) score(mk(EV_VLD, 4'd0, 1'b1, 8'h00));
        if (usb.data_strobe && !ds_prev && usb.direction_in)
          score(mk(EV_INB, 4'd0, usb.data_in_valid, usb.data_in));
        for (int i = 0; i < NUM_EP; i++) if (ep_out_wr[i])     score(mk(EV_WR, 4'(i), out_is_setup, out_byte));
        for (int i = 0; i < NUM_EP; i++) if (ep_out_commit[i]) score(mk(EV_COMMIT, 4'(i), 1'b0, 8'h00));
        for (int i = 0; i < NUM_EP; i++) if (ep_out_abort[i])  score(mk(EV_ABORT, 4'(i), 1'b0, 8'h00));
        for (int i = 0; i < NUM_EP; i++) if (ep_in_done[i])    score(mk(EV_DONE, 4'(i), 1'b0, 8'h00));
      end
      ta_prev  = usb.transaction_active;
      ds_prev  = usb.data_strobe;
      vld_prev = usb.data_in_valid;
    end
  end

  task automatic tick();
    @(posedge clk48mhz);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic tok(input logic [3:0] ep, input logic din, input logic stp);
    usb.endpoint = ep; usb.direction_in = din; usb.setup = stp;
    usb.transaction_active = 1'b1;
    ticks(3);
  endtask

  task automatic strobe(input logic [7:0] b);
    usb.data_out = b; usb.data_strobe = 1'b1;
    tick();
    usb.data_strobe = 1'b0;
    tick();
  endtask

  task automatic fin(input logic succ);
    usb.success = succ; usb.transaction_active = 1'b0;
    tick();
    usb.success = 1'b0; usb.setup = 1'b0; usb.direction_in = 1'b0;
    ticks(2);
  endtask

  // Token on an endpoint that is not ready: reports the stored toggle with NAK.
  task automatic probe(input logic [3:0] ep, input logic din, input logic tog);
    push_hs(hs_nak, tog);
    tok(ep, din, 1'b0);
    fin(1'b0);
  endtask

  initial begin
    ev_t left;
    usb.endpoint = '0; usb.transaction_active = 1'b0; usb.direction_in = 1'b0;
    usb.setup = 1'b0; usb.data_strobe = 1'b0; usb.success = 1'b0; usb.data_out = '0;
    ep_stall = '0; ep_in_ready = '0; ep_out_ready = '1;
    rst = 1'b1; usb_rst = 1'b0;
    ticks(3);
    chk("rst_handshake", 32'(usb.handshake), 32'd0);
    chk("rst_data_toggle", 32'(usb.data_toggle), 32'd0);
    chk("rst_data_in", 32'(usb.data_in), 32'd0);
    chk("rst_data_in_valid", 32'(usb.data_in_valid), 32'd0);
    chk("rst_in_addr", 32'(in_addr), 32'd0);
    chk("rst_out_is_setup", 32'(out_is_setup), 32'd0);
    chk("rst_pulses", 32'({ep_in_done, ep_out_wr, ep_out_commit, ep_out_abort}), 32'd0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // SETUP EP0, 8 bytes, committed; both EP0 toggles become 1
    push_hs(hs_ack, 1'b0);
    tok(4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push(EV_WR, 4'd0, 1'b1, 8'h80 + 8'(i));
      strobe(8'h80 + 8'(i));
    end
    push(EV_COMMIT, 4'd0, 1'b0, 8'h00);
    fin(1'b1);
    probe(4'd0, 1'b1, 1'b1);
    ep_out_ready[0] = 1'b0;
    probe(4'd0, 1'b0, 1'b1);
    ep_out_ready[0] = 1'b1;

    // IN EP1, 3 bytes, ACKed
    ep_in_ready[1] = 1'b1;
    push_hs(hs_ack, 1'b0);
    push(EV_VLD, 4'd0, 1'b1, 8'h00);
    tok(4'd1, 1'b1, 1'b0);
    push(EV_INB, 4'd0, 1'b1, 8'h4A); strobe(8'h00);
    push(EV_INB, 4'd0, 1'b1, 8'h4B); strobe(8'h00);
    push(EV_INB, 4'd0, 1'b1, 8'h48); strobe(8'h00);
    push(EV_DONE, 4'd1, 1'b0, 8'h00);
    fin(1'b1);
    ep_in_ready[1] = 1'b0;
    probe(4'd1, 1'b1, 1'b1);

    // IN EP2 not ready: NAK, no data
    push_hs(hs_nak, 1'b0);
    tok(4'd2, 1'b1, 1'b0);
    ticks(4);
    fin(1'b1);
    probe(4'd2, 1'b1, 1'b0);

    // OUT EP1, 65 bytes: overflow aborts, toggle kept
    push_hs(hs_ack, 1'b0);
    tok(4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 65; i++) begin
      if (i < MAX_PKT) push(EV_WR, 4'd1, 1'b0, 8'(i));
      strobe(8'(i));
    end
    push(EV_ABORT, 4'd1, 1'b0, 8'h00);
    fin(1'b1);
    ep_out_ready[1] = 1'b0;
    probe(4'd1, 1'b0, 1'b0);
    ep_out_ready[1] = 1'b1;

    // OUT EP1, 2 bytes committed: out toggle flips
    push_hs(hs_ack, 1'b0);
    tok(4'd1, 1'b0, 1'b0);
    push(EV_WR, 4'd1, 1'b0, 8'hC3); strobe(8'hC3);
    push(EV_WR, 4'd1, 1'b0, 8'h3C); strobe(8'h3C);
    push(EV_COMMIT, 4'd1, 1'b0, 8'h00);
    fin(1'b1);
    ep_out_ready[1] = 1'b0;
    probe(4'd1, 1'b0, 1'b1);
    ep_out_ready[1] = 1'b1;

    // Stall cases: EP5 out of range, halted EP0 still takes SETUP, halted EP1 IN
    push_hs(hs_stall, 1'b0);
    tok(4'd5, 1'b1, 1'b0);
    fin(1'b1);
    ep_stall[0] = 1'b1;
    push_hs(hs_ack, 1'b0);
    tok(4'd0, 1'b0, 1'b1);
    push(EV_COMMIT, 4'd0, 1'b0, 8'h00);
    fin(1'b1);
    ep_stall = 4'b0010;
    ep_in_ready[1] = 1'b1;
    push_hs(hs_stall, 1'b1);
    tok(4'd1, 1'b1, 1'b0);
    fin(1'b1);
    ep_stall = '0;

    // IN EP1 without success: no done, toggle kept
    push_hs(hs_ack, 1'b1);
    push(EV_VLD, 4'd0, 1'b1, 8'h00);
    tok(4'd1, 1'b1, 1'b0);
    push(EV_INB, 4'd0, 1'b1, 8'h4A); strobe(8'h00);
    fin(1'b0);
    ep_in_ready[1] = 1'b0;
    probe(4'd1, 1'b1, 1'b1);

    // Bus reset in the middle of an OUT: silent return to idle, toggles cleared
    push_hs(hs_ack, 1'b0);
    tok(4'd2, 1'b0, 1'b0);
    push(EV_WR, 4'd2, 1'b0, 8'h11); strobe(8'h11);
    push(EV_WR, 4'd2, 1'b0, 8'h22); strobe(8'h22);
    usb_rst = 1'b1;
    tick();
    usb_rst = 1'b0;
    tick();
    chk("usbrst_in_addr", 32'(in_addr), 32'd0);
    chk("usbrst_handshake", 32'(usb.handshake), 32'd0);
    strobe(8'h33);
    fin(1'b1);
    probe(4'd1, 1'b1, 1'b0);
    ep_out_ready[1] = 1'b0;
    probe(4'd1, 1'b0, 1'b0);
    ep_out_ready[1] = 1'b1;
    probe(4'd0, 1'b1, 1'b0);

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick();
    while (exp_q.size() > 0) begin
      left = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_%s: got no event, required ep=%0d flag=%0b data=%02h",
               kname(left.kind), left.ep, left.flag, left.data);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
